// File: rtl/square_osc.sv
// ---------------------------------------------------------------------------
// square_osc
// Purpose : turns a registered half-period count into a 50%-duty square wave.
//           The output toggles every activePeriod clock cycles. A new period
//           is taken only at a half-period boundary, so no glitch or runt
//           pulse can appear. Releasing the gate lets the current cycle end
//           cleanly on a falling edge. A note-on pulse restarts the phase.
// Ports   :
//   clk_i           system clock
//   rst_i           synchronous, active-high reset
//   en_i            gate, 1 = note held
//   noteOn_i        single-cycle pulse on a new note, restarts phase
//   halfCntPeriod_i half-period in clk cycles, 0 = silent
//   wave_o          square wave (registered)
//   edge_o          one-cycle pulse coincident with every wave_o toggle
//   active_o        1 while the oscillator is not idle
// ---------------------------------------------------------------------------
module square_osc #(
   parameter int BW = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          en_i,
   input  logic          noteOn_i,
   input  logic [BW-1:0] halfCntPeriod_i,
   output logic          wave_o,
   output logic          edge_o,
   output logic          active_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_STOP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [BW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] period_q, period_d;
   logic          wave_q, wave_d;
   logic          edge_q, edge_d;
   logic          active_q, active_d;

   logic          period_ok_s;
   logic          boundary_s;
   logic          run_like_s;

   // A zero period means "silent"; outside IDLE period_q is never zero, so the
   // boundary compare cannot underflow into a wrapping counter.
   assign period_ok_s = (halfCntPeriod_i != {BW{1'b0}});
   assign boundary_s  = (cnt_q == (period_q - {{(BW-1){1'b0}}, 1'b1}));
   // STOP behaves exactly like RUN once the gate is held again with a valid
   // period, so the phase carries on without a discontinuity.
   assign run_like_s  = (state_q == ST_RUN) || (en_i && period_ok_s);

   // Next-state logic: note-on restarts, otherwise per-state boundary handling.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      wave_d   = wave_q;
      edge_d   = 1'b0;

      if (noteOn_i) begin
         cnt_d    = {BW{1'b0}};
         wave_d   = 1'b0;
         period_d = halfCntPeriod_i;
         if (en_i && period_ok_s) begin
            state_d = ST_RUN;
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               wave_d = 1'b0;
               cnt_d  = {BW{1'b0}};
               if (en_i && period_ok_s) begin
                  state_d  = ST_RUN;
                  period_d = halfCntPeriod_i;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
            ST_RUN, ST_STOP: begin
               if (run_like_s) begin
                  if (boundary_s) begin
                     cnt_d  = {BW{1'b0}};
                     wave_d = ~wave_q;
                     edge_d = 1'b1;
                     // A silent period at the boundary keeps the old period
                     // so the wave can still finish its cycle in STOP.
                     if (period_ok_s) begin
                        period_d = halfCntPeriod_i;
                     end else begin
                        period_d = period_q;
                     end
                     if (en_i && period_ok_s) begin
                        state_d = ST_RUN;
                     end else begin
                        state_d = ST_STOP;
                     end
                  end else begin
                     cnt_d = cnt_q + {{(BW-1){1'b0}}, 1'b1};
                     if (en_i) begin
                        state_d = ST_RUN;
                     end else begin
                        state_d = ST_STOP;
                     end
                  end
               end else begin
                  // Stopping: the next boundary ends the note. A 1->0 toggle
                  // still happens; a 0->1 toggle is suppressed.
                  if (boundary_s) begin
                     cnt_d   = {BW{1'b0}};
                     state_d = ST_IDLE;
                     if (wave_q) begin
                        wave_d = 1'b0;
                        edge_d = 1'b1;
                     end else begin
                        wave_d = 1'b0;
                        edge_d = 1'b0;
                     end
                  end else begin
                     cnt_d   = cnt_q + {{(BW-1){1'b0}}, 1'b1};
                     state_d = ST_STOP;
                  end
               end
            end
            default: begin
               state_d  = ST_IDLE;
               cnt_d    = {BW{1'b0}};
               wave_d   = 1'b0;
               period_d = {BW{1'b0}};
            end
         endcase
      end

      active_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= {BW{1'b0}};
         period_q <= {BW{1'b0}};
         wave_q   <= 1'b0;
         edge_q   <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         wave_q   <= wave_d;
         edge_q   <= edge_d;
         active_q <= active_d;
      end
   end

   assign wave_o   = wave_q;
   assign edge_o   = edge_q;
   assign active_o = active_q;

endmodule

// File: tb/tb_square_osc.sv
// ---------------------------------------------------------------------------
// tb_square_osc
// Purpose : directed self-checking bench for square_osc. Inputs change 1 time
//           unit after the rising edge; outputs are sampled at the same point,
//           i.e. they show the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_square_osc;

   localparam int BW = 16;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          en_i;
   logic          noteOn_i;
   logic [BW-1:0] halfCntPeriod_i;
   logic          wave_o;
   logic          edge_o;
   logic          active_o;

   int n_checks = 0;
   int n_fail   = 0;

   square_osc #(.BW(BW)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .en_i            (en_i),
      .noteOn_i        (noteOn_i),
      .halfCntPeriod_i (halfCntPeriod_i),
      .wave_o          (wave_o),
      .edge_o          (edge_o),
      .active_o        (active_o)
   );

   // Free-running clock, period 10.
   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Run n edges; pattern bit for cycle i is at index n-1-i (leftmost = first).
   task automatic expect_pat(input string tag, input int n, input logic [63:0] w,
                             input logic [63:0] e, input logic [63:0] a);
      for (int i = 0; i < n; i++) begin
         tick();
         check_eq($sformatf("%s wave c%0d", tag, i), {31'd0, wave_o}, {31'd0, w[n-1-i]});
         check_eq($sformatf("%s edge c%0d", tag, i), {31'd0, edge_o}, {31'd0, e[n-1-i]});
         check_eq($sformatf("%s act c%0d", tag, i), {31'd0, active_o}, {31'd0, a[n-1-i]});
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      en_i = 1'b0;
      noteOn_i = 1'b0;
      halfCntPeriod_i = 16'd0;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   // Leave IDLE with period p; returns right after the edge that enters RUN.
   task automatic start_run(input logic [BW-1:0] p);
      halfCntPeriod_i = p;
      en_i = 1'b1;
      tick();
      check_eq("enter run active", {31'd0, active_o}, 32'd1);
      check_eq("enter run wave", {31'd0, wave_o}, 32'd0);
   endtask

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin
      rst_i = 1'b1;
      en_i = 1'b0;
      noteOn_i = 1'b0;
      halfCntPeriod_i = 16'd0;

      // 1. Reset dominates random inputs.
      for (int i = 0; i < 2; i++) begin
         en_i = 1'($urandom_range(0, 1));
         noteOn_i = 1'($urandom_range(0, 1));
         halfCntPeriod_i = 16'($urandom_range(1, 65535));
         tick();
         check_eq("rst wave", {31'd0, wave_o}, 32'd0);
         check_eq("rst edge", {31'd0, edge_o}, 32'd0);
         check_eq("rst act", {31'd0, active_o}, 32'd0);
      end
      rst_i = 1'b0;
      en_i = 1'b0;
      noteOn_i = 1'b0;
      halfCntPeriod_i = 16'd0;
      expect_pat("post rst", 2, 64'b00, 64'b00, 64'b00);

      // 2. P=4 sustained for 10 periods: rise 4 edges after RUN entry.
      do_reset();
      start_run(16'd4);
      for (int i = 1; i <= 80; i++) begin
         tick();
         check_eq($sformatf("p4 wave e%0d", i), {31'd0, wave_o}, ((i / 4) % 2 == 1) ? 32'd1 : 32'd0);
         check_eq($sformatf("p4 edge e%0d", i), {31'd0, edge_o}, (i % 4 == 0) ? 32'd1 : 32'd0);
         check_eq($sformatf("p4 act e%0d", i), {31'd0, active_o}, 32'd1);
      end

      // 3. P=4 -> 2 changed at cnt=1 of the high half.
      do_reset();
      start_run(16'd4);
      expect_pat("chg a", 5, 64'b00011, 64'b00010, ONES);
      halfCntPeriod_i = 16'd2;
      expect_pat("chg b", 8, 64'b11001100, 64'b00101010, ONES);

      // 4a. P=3, gate dropped while high: finishes high, falls, idle.
      do_reset();
      start_run(16'd3);
      expect_pat("stop hi a", 4, 64'b0011, 64'b0010, ONES);
      en_i = 1'b0;
      expect_pat("stop hi b", 4, 64'b1000, 64'b0100, 64'b1000);

      // 4b. P=3, gate dropped while low: rise suppressed, idle.
      do_reset();
      start_run(16'd3);
      expect_pat("stop lo a", 7, 64'b0011100, 64'b0010010, ONES);
      en_i = 1'b0;
      expect_pat("stop lo b", 4, 64'b0000, 64'b0000, 64'b1000);

      // 4c. Gate reasserted during STOP: phase continues.
      do_reset();
      start_run(16'd3);
      expect_pat("rearm a", 4, 64'b0011, 64'b0010, ONES);
      en_i = 1'b0;
      expect_pat("rearm b", 1, 64'b1, 64'b0, 64'b1);
      en_i = 1'b1;
      expect_pat("rearm c", 7, 64'b0001110, 64'b1001001, ONES);

      // 5. P=5 high, note-on with P=7 restarts low; then note-on with P=0.
      do_reset();
      start_run(16'd5);
      expect_pat("non a", 7, 64'b0000111, 64'b0000100, ONES);
      noteOn_i = 1'b1;
      halfCntPeriod_i = 16'd7;
      tick();
      check_eq("non restart wave", {31'd0, wave_o}, 32'd0);
      check_eq("non restart edge", {31'd0, edge_o}, 32'd0);
      check_eq("non restart act", {31'd0, active_o}, 32'd1);
      noteOn_i = 1'b0;
      expect_pat("non b", 9, 64'b000000111, 64'b000000100, ONES);
      noteOn_i = 1'b1;
      halfCntPeriod_i = 16'd0;
      expect_pat("non zero", 1, 64'b0, 64'b0, 64'b0);
      noteOn_i = 1'b0;
      expect_pat("non zero idle", 3, 64'b000, 64'b000, 64'b000);

      // 6a. P=1 toggles every cycle.
      do_reset();
      start_run(16'd1);
      expect_pat("p1", 8, 64'b10101010, 64'b11111111, ONES);

      // 6b. P=0 with gate held stays idle.
      do_reset();
      halfCntPeriod_i = 16'd0;
      en_i = 1'b1;
      expect_pat("p0", 4, 64'b0000, 64'b0000, 64'b0000);

      // 6c. Reset mid-RUN while high clears all outputs on the next edge.
      do_reset();
      start_run(16'd3);
      expect_pat("mid rst a", 4, 64'b0011, 64'b0010, ONES);
      rst_i = 1'b1;
      expect_pat("mid rst b", 1, 64'b0, 64'b0, 64'b0);
      rst_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
